// File: rtl/timer_arb_pkg.sv
// Shared types and helpers for the round-robin interval timer arbiter.
package timer_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tarb_state_e;

    localparam int TARB_CNT_W = 16;

    // One-hot winner among up to 8 requesters, searching upward from last+1 with wrap.
    function automatic logic [7:0] rr_next(input logic [7:0] req, input logic [2:0] last,
                                           input int n);
        logic [7:0] oh;
        logic [2:0] idx;
        logic       found;
        oh    = '0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            if (k <= n && !found) begin
                idx = 3'((int'(last) + k) % n);
                if (req[idx]) begin
                    oh[idx] = 1'b1;
                    found   = 1'b1;
                end
            end
        end
        return oh;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: one-hot winner plus its index.
module rr_pick
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] last_winner,
    output logic [N_REQ-1:0] grant_oh,
    output logic [IDX_W-1:0] idx
);

    logic [7:0] req_ext;
    logic [2:0] last_ext;
    logic [7:0] oh;

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        req_ext                 = '0;
        last_ext                = '0;
        req_ext[N_REQ-1:0]      = req;
        last_ext[IDX_W-1:0]     = last_winner;
        oh                      = rr_next(req_ext, last_ext, N_REQ);
        grant_oh                = oh[N_REQ-1:0];
        idx                     = '0;
        for (int i = 0; i < 8; i++) begin
            if (oh[i]) idx = IDX_W'(i);
        end
    end

endmodule

// File: rtl/timer_arbiter.sv
// Round-robin scheduler sharing one interval counter among N_REQ requesters.
module timer_arbiter
    import timer_arb_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int CNT_W = TARB_CNT_W
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_len,
    input  logic                   abort,
    output logic [N_REQ-1:0]       grant,
    output logic                   busy,
    output logic [CNT_W-1:0]       count,
    output logic [N_REQ-1:0]       done,
    output logic                   aborted
);

    localparam int IDX_W = $clog2(N_REQ);

    tarb_state_e      state_q, state_d;
    logic [N_REQ-1:0] grant_q, grant_d, done_q, done_d;
    logic             busy_q, busy_d, aborted_q, aborted_d;
    logic [CNT_W-1:0] count_q, count_d, target_q, target_d;
    logic [IDX_W-1:0] win_q, win_d, last_q, last_d;
    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic [CNT_W-1:0] sel_len;

    rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req         (req),
        .last_winner (last_q),
        .grant_oh    (pick_oh),
        .idx         (pick_idx)
    );

    assign sel_len = req_len[int'(pick_idx)*CNT_W +: CNT_W];

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        busy_d    = busy_q;
        count_d   = count_q;
        target_d  = target_q;
        win_d     = win_q;
        last_d    = last_q;
        done_d    = '0;
        aborted_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d  = RUN;
                    grant_d  = pick_oh;
                    busy_d   = 1'b1;
                    count_d  = '0;
                    win_d    = pick_idx;
                    // A zero length still occupies the counter for one cycle.
                    target_d = (sel_len == '0) ? CNT_W'(1) : sel_len;
                end
            end
            RUN: begin
                if (count_q == target_q - CNT_W'(1)) begin
                    state_d = DONE;
                    done_d  = grant_q;
                end else if (abort) begin
                    state_d   = DONE;
                    done_d    = grant_q;
                    aborted_d = 1'b1;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                grant_d = '0;
                busy_d  = 1'b0;
                last_d  = win_q;
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            target_q  <= '0;
            win_q     <= '0;
            last_q    <= IDX_W'(N_REQ - 1);
            done_q    <= '0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            target_q  <= target_d;
            win_q     <= win_d;
            last_q    <= last_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
        end
    end

    assign grant   = grant_q;
    assign busy    = busy_q;
    assign count   = count_q;
    assign done    = done_q;
    assign aborted = aborted_q;

endmodule

// File: tb/tb_timer_arbiter.sv
// Scoreboard bench for timer_arbiter: expected completions queued by stimulus, checked by a monitor.
module tb_timer_arbiter;

    localparam int N = 4;
    localparam int W = 16;

    typedef struct {
        logic [N-1:0] done;
        logic         aborted;
        logic [W-1:0] count;
    } exp_t;

    logic           clock = 1'b0;
    logic           reset = 1'b1;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] req_len = '0;
    logic           abort = 1'b0;
    logic [N-1:0]   grant, done;
    logic           busy, aborted;
    logic [W-1:0]   count;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    exp_t exp_q[$];
    int   gcyc_q[$];
    logic [N-1:0] gval_q[$];
    logic [N-1:0] prev_grant = '0;

    timer_arbiter #(.N_REQ(N), .CNT_W(W)) dut (
        .clock   (clock),
        .reset   (reset),
        .req     (req),
        .req_len (req_len),
        .abort   (abort),
        .grant   (grant),
        .busy    (busy),
        .count   (count),
        .done    (done),
        .aborted (aborted)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: compares each done pulse against the next queued expectation, logs grant starts.
    always @(negedge clock) begin
        if (|done) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 32'(done), 32'h0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("done_vec", 32'(done), 32'(e.done));
                check("done_aborted", 32'(aborted), 32'(e.aborted));
                check("done_count", 32'(count), 32'(e.count));
            end
        end
        if (grant != '0 && prev_grant == '0) begin
            gcyc_q.push_back(cyc);
            gval_q.push_back(grant);
        end
        prev_grant = grant;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        abort = 1'b0;
        step();
        reset = 1'b0;
    endtask

    task automatic wait_count(input logic [W-1:0] v);
        for (int i = 0; i < 200; i++) begin
            if (busy && count == v) return;
            step();
        end
        check("wait_count_timeout", 32'(count), 32'(v));
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200; i++) begin
            if (!busy) return;
            step();
        end
        check("wait_idle_timeout", 32'(busy), 32'h0);
    endtask

    initial begin
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_count", 32'(count), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        step();
        reset = 1'b0;

        // Single run of length 5 on requester 0.
        req_len[0*W +: W] = 16'd5;
        req = 4'b0001;
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd4});
        step();
        check("t1_grant", 32'(grant), 32'h1);
        check("t1_busy", 32'(busy), 32'h1);
        check("t1_count0", 32'(count), 32'h0);
        req = '0;
        for (int k = 1; k <= 4; k++) begin
            step();
            check("t1_count_step", 32'(count), 32'(k));
        end
        step();
        check("t1_done_grant_held", 32'(grant), 32'h1);
        check("t1_done_count", 32'(count), 32'h4);
        step();
        check("t1_grant_fall", 32'(grant), 32'h0);
        check("t1_busy_fall", 32'(busy), 32'h0);
        check("t1_count_hold", 32'(count), 32'h4);

        // All four requesting, length 2: order 0,1,2,3,0 with 4-cycle spacing.
        do_reset();
        for (int i = 0; i < N; i++) req_len[i*W +: W] = 16'd2;
        gcyc_q.delete();
        gval_q.delete();
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd1});
        exp_q.push_back('{done: 4'b0010, aborted: 1'b0, count: 16'd1});
        exp_q.push_back('{done: 4'b0100, aborted: 1'b0, count: 16'd1});
        exp_q.push_back('{done: 4'b1000, aborted: 1'b0, count: 16'd1});
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd1});
        req = 4'b1111;
        for (int i = 0; i < 100 && gcyc_q.size() < 5; i++) step();
        req = '0;
        wait_idle();
        check("t2_grants_seen", 32'(gcyc_q.size()), 32'd5);
        if (gcyc_q.size() >= 5) begin
            logic [N-1:0] order [5];
            order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
            for (int i = 0; i < 5; i++) check("t2_order", 32'(gval_q[i]), 32'(order[i]));
            for (int i = 1; i < 5; i++) check("t2_gap", 32'(gcyc_q[i] - gcyc_q[i-1]), 32'd4);
        end

        // Zero length behaves as length 1.
        do_reset();
        req_len[0*W +: W] = 16'd0;
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd0});
        req = 4'b0001;
        step();
        req = '0;
        check("t3_grant", 32'(grant), 32'h1);
        check("t3_count", 32'(count), 32'h0);
        step();
        check("t3_done_now", 32'(done), 32'h1);
        step();
        check("t3_idle", 32'(busy), 32'h0);

        // Abort at count 3 and at count 9 of a length-10 run; abort while idle is ignored.
        do_reset();
        abort = 1'b1;
        step();
        check("t4_abort_idle", 32'(busy), 32'h0);
        abort = 1'b0;
        req_len[0*W +: W] = 16'd10;
        exp_q.push_back('{done: 4'b0001, aborted: 1'b1, count: 16'd3});
        req = 4'b0001;
        step();
        req = '0;
        wait_count(16'd3);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("t4_abort_count", 32'(count), 32'h3);
        wait_idle();
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd9});
        req = 4'b0001;
        step();
        req = '0;
        wait_count(16'd9);
        abort = 1'b1;
        step();
        abort = 1'b0;
        wait_idle();

        // Reset mid-run drops the run with no done pulse; requester 0 wins first afterwards.
        req_len[1*W +: W] = 16'd20;
        req = 4'b0010;
        step();
        req = '0;
        check("t5_grant1", 32'(grant), 32'h2);
        wait_count(16'd7);
        #2 reset = 1'b1;
        #1;
        check("t5_rst_grant", 32'(grant), 32'h0);
        check("t5_rst_busy", 32'(busy), 32'h0);
        check("t5_rst_count", 32'(count), 32'h0);
        step();
        reset = 1'b0;
        req_len[0*W +: W] = 16'd3;
        exp_q.push_back('{done: 4'b0001, aborted: 1'b0, count: 16'd2});
        req = 4'b0011;
        step();
        req = '0;
        check("t5_first_after_rst", 32'(grant), 32'h1);
        wait_idle();

        // Changing req/req_len mid-run does not affect the latched length.
        req_len[1*W +: W] = 16'd4;
        exp_q.push_back('{done: 4'b0010, aborted: 1'b0, count: 16'd3});
        req = 4'b0010;
        step();
        check("t6_grant", 32'(grant), 32'h2);
        req = '0;
        req_len[1*W +: W] = 16'd9;
        wait_idle();

        repeat (3) step();
        check("queue_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
